counter_updown: RTL and testbench
=================================

# counter_updown

Parametrised up/down counter, the next generation of the team's simple 4-bit counter for the digital example flow. Adds configurable width and modulus, a step prescaler, direction control, synchronous clear and load, wrap-or-saturate mode, and terminal-count and sticky-wrap status. Intended as the reusable counting primitive for timers, dividers and event counters in the digital examples.

## Interface

- WIDTH, 4: counter width in bits, 2..32.
- MAX_VALUE, 2**WIDTH-1: top of the count range; range is 0..MAX_VALUE; 1 ≤ MAX_VALUE ≤ 2**WIDTH-1.
- PRESCALE, 1: number of enabled cycles per count step, 1..65536.

- clk_i  in  1  clock, rising-edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous clear.
- load_i  in  1  synchronous load of load_value_i.
- load_value_i  in  WIDTH  value to load; clamped to MAX_VALUE.
- enable_i  in  1  count enable; feeds the prescaler.
- up_i  in  1  direction: 1 = up, 0 = down.
- saturate_i  in  1  boundary mode: 1 = hold at bound, 0 = wrap.
- out_o  out  WIDTH  current count, registered.
- tc_o  out  1  terminal-count pulse, registered.
- wrapped_o  out  1  sticky flag: at least one wrap since the last clear or reset.

## Operation

- **Reset:** reset_n_i low forces out_o=0, tc_o=0, wrapped_o=0 and prescaler=0 immediately, with no clock edge required. Release is synchronous to clk_i; the first update occurs on the first rising edge after release.
- **Priority per edge:** clear_i > load_i > step.
  - **clear_i=1:** out_o=0, prescaler=0, wrapped_o=0, tc_o=0.
  - **load_i=1:** out_o=min(load_value_i, MAX_VALUE), prescaler=0, tc_o=0; wrapped_o unchanged.
- **Prescaler:** internal counter 0..PRESCALE-1, advancing only when enable_i=1 and no clear/load.
  - A step fires when enable_i=1 and prescaler==PRESCALE-1; prescaler returns to 0.
  - With PRESCALE=1, every enabled cycle steps.
  - enable_i=0 freezes both the prescaler and the count.
- **Step up:**
  - out_o<MAX_VALUE: out_o+1.
  - out_o==MAX_VALUE and saturate_i=0: out_o=0, wrapped_o=1.
  - out_o==MAX_VALUE and saturate_i=1: out_o holds.
- **Step down:**
  - out_o>0: out_o-1.
  - out_o==0 and saturate_i=0: out_o=MAX_VALUE, wrapped_o=1.
  - out_o==0 and saturate_i=1: out_o holds.
- **tc_o:** 1 for exactly the cycle following any step taken at the bound in the current direction (wrap or saturate); 0 otherwise.
  - Consecutive steps at the bound in saturate mode hold tc_o high on every such cycle.
- **Arithmetic:** internal comparisons use WIDTH bits; MAX_VALUE < 2**WIDTH-1 gives modulo-(MAX_VALUE+1) counting with no intermediate out-of-range value.
- **Mid-count changes:** up_i and saturate_i may change on any cycle and take effect on the next step. No state is kept beyond out_o, the prescaler and wrapped_o.

## Timing

- All outputs are registered; latency is 1 cycle from input sample to output.
- Clear/load to out_o: the value is visible after the same edge that samples them.
- Step rate: one step per PRESCALE enabled cycles; the first step after reset, clear or load occurs on the PRESCALE-th enabled edge.
- tc_o and the wrapped_o set are coincident with the out_o update that wraps or saturates.
- Asynchronous reset asserted mid-operation overrides everything, including a step in progress.

## Test plan

- **Reset:** WIDTH=4, defaults; count to 5, pulse reset_n_i low between edges -> out_o=0 and wrapped_o=0 before the next edge; counting resumes 1, 2, … after release.
- **Up wrap:** MAX_VALUE=9, PRESCALE=1, up, wrap; enable 12 cycles -> out_o sequence 1..9, 0, 1, 2; tc_o high only in the cycle out_o becomes 0; wrapped_o=1 from then on.
- **Down saturate:** MAX_VALUE=9, load 2, down, saturate_i=1; enable 4 cycles -> out_o 1, 0, 0, 0; tc_o high on the last two cycles; wrapped_o stays 0.
- **Prescaler and enable gaps:** PRESCALE=3, up; enable pattern 1,1,0,1,1,1,1 -> out_o steps to 1 on the 4th edge (third enabled cycle) and to 2 on the 7th edge.
- **Priority and clamp:** MAX_VALUE=9; clear_i and load_i together with value 7 -> out_o=0, wrapped_o=0. Load 15 -> out_o=9. Load while enable_i=1 with prescaler mid-count -> no step that edge; prescaler restarts.
- **Direction change at bound:** MAX_VALUE=9, out_o=9, wrap mode; flip up_i from 1 to 0 then step -> out_o=8, tc_o=0, wrapped_o unchanged.

Source files
------------

// File: rtl/counter_updown.sv
// counter_updown: parametrised up/down counter with prescaler, clear/load, wrap-or-saturate and status flags
module counter_updown #(
    parameter int unsigned            WIDTH     = 4,
    parameter logic [WIDTH-1:0]       MAX_VALUE = {WIDTH{1'b1}},
    parameter int unsigned            PRESCALE  = 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             enable_i,
    input  logic             up_i,
    input  logic             saturate_i,
    output logic [WIDTH-1:0] out_o,
    output logic             tc_o,
    output logic             wrapped_o
);
    localparam int unsigned     PW      = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] out_d, out_q;
    logic [PW-1:0]    ps_d, ps_q;
    logic             tc_d, tc_q;
    logic             wrapped_d, wrapped_q;
    logic             step;
    logic             at_bound;

    // Next state: clear beats load beats a prescaled step; a step at the bound wraps or holds
    always_comb begin
        step      = enable_i && ps_q == PS_LAST;
        at_bound  = up_i ? out_q == MAX_VALUE : out_q == '0;
        out_d     = out_q;
        ps_d      = ps_q;
        tc_d      = 1'b0;
        wrapped_d = wrapped_q;
        if (clear_i) begin
            out_d     = '0;
            ps_d      = '0;
            wrapped_d = 1'b0;
        end else if (load_i) begin
            out_d = load_value_i > MAX_VALUE ? MAX_VALUE : load_value_i;
            ps_d  = '0;
        end else if (enable_i) begin
            ps_d = step ? '0 : ps_q + PW'(1);
            if (step) begin
                tc_d = at_bound;
                if (!at_bound) begin
                    out_d = up_i ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
                end else if (!saturate_i) begin
                    out_d     = up_i ? '0 : MAX_VALUE;
                    wrapped_d = 1'b1;
                end
            end
        end
    end

    // State registers; reset clears everything without waiting for a clock
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_q     <= '0;
            ps_q      <= '0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            ps_q      <= ps_d;
            tc_q      <= tc_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign out_o     = out_q;
    assign tc_o      = tc_q;
    assign wrapped_o = wrapped_q;
endmodule

// File: tb/tb_counter_updown.sv
// tb_counter_updown: directed checks of counter_updown in three configurations sharing one stimulus
module tb_counter_updown;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       saturate = 1'b0;

    logic [3:0] out0, out1, out2;
    logic       tc0, tc1, tc2;
    logic       wr0, wr1, wr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Defaults: 0..15, step every enabled cycle
    counter_updown u_d0 (
        .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .load_i(load),
        .load_value_i(load_value), .enable_i(enable), .up_i(up), .saturate_i(saturate),
        .out_o(out0), .tc_o(tc0), .wrapped_o(wr0)
    );

    // Decade counter, step every enabled cycle
    counter_updown #(.WIDTH(4), .MAX_VALUE(4'd9), .PRESCALE(1)) u_d1 (
        .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .load_i(load),
        .load_value_i(load_value), .enable_i(enable), .up_i(up), .saturate_i(saturate),
        .out_o(out1), .tc_o(tc1), .wrapped_o(wr1)
    );

    // Decade counter, step every third enabled cycle
    counter_updown #(.WIDTH(4), .MAX_VALUE(4'd9), .PRESCALE(3)) u_d2 (
        .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .load_i(load),
        .load_value_i(load_value), .enable_i(enable), .up_i(up), .saturate_i(saturate),
        .out_o(out2), .tc_o(tc2), .wrapped_o(wr2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [6:0] en_pat = 7'b1111011;
        int       p_exp[7] = '{0, 0, 0, 1, 1, 1, 2};
        // reset held from time 0
        #12;
        check("rst_out", out0, 0);
        check("rst_tc", tc0, 0);
        check("rst_wr", wr0, 0);
        reset_n = 1'b1;
        enable = 1'b1;
        repeat (5) tick();
        check("cnt5_d0", out0, 5);
        check("cnt5_d2", out2, 1);
        // asynchronous reset between edges
        reset_n = 1'b0;
        #2;
        check("async_out", out0, 0);
        check("async_wr", wr0, 0);
        #1;
        reset_n = 1'b1;
        tick();
        check("resume1", out0, 1);
        tick();
        check("resume2", out0, 2);

        // up wrap on decade counter
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_out", out1, 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("upw_out%0d", i), out1, i % 10);
            check($sformatf("upw_tc%0d", i), tc1, i == 10);
            check($sformatf("upw_wr%0d", i), wr1, i >= 10);
        end

        // down saturate from 2
        enable = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load = 1'b1;
        load_value = 4'd2;
        tick();
        check("ld2", out1, 2);
        load = 1'b0;
        up = 1'b0;
        saturate = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("dns_out%0d", i), out1, i == 0 ? 1 : 0);
            check($sformatf("dns_tc%0d", i), tc1, i >= 2);
            check($sformatf("dns_wr%0d", i), wr1, 0);
        end

        // prescaler with an enable gap
        saturate = 1'b0;
        up = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            enable = en_pat[i];
            tick();
            check($sformatf("ps_out%0d", i), out2, p_exp[i]);
        end

        // priority and clamp
        enable = 1'b0;
        load = 1'b1;
        load_value = 4'd9;
        tick();
        load = 1'b0;
        enable = 1'b1;
        tick();
        check("pre_wrap_out", out1, 0);
        check("pre_wrap_tc", tc1, 1);
        check("pre_wrap_wr", wr1, 1);
        enable = 1'b0;
        clear = 1'b1;
        load = 1'b1;
        load_value = 4'd7;
        tick();
        check("clrld_out", out1, 0);
        check("clrld_wr", wr1, 0);
        clear = 1'b0;
        load_value = 4'd15;
        tick();
        check("clamp_d1", out1, 9);
        check("clamp_d0", out0, 15);
        check("clamp_tc", tc1, 0);

        // load while the prescaler is mid-count
        load = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        check("mid_pre", out2, 0);
        load = 1'b1;
        load_value = 4'd4;
        tick();
        check("mid_ld", out2, 4);
        load = 1'b0;
        tick();
        tick();
        check("mid_hold", out2, 4);
        tick();
        check("mid_step", out2, 5);

        // direction change at the upper bound
        enable = 1'b0;
        load = 1'b1;
        load_value = 4'd15;
        tick();
        check("dir_ld", out1, 9);
        load = 1'b0;
        up = 1'b0;
        enable = 1'b1;
        tick();
        check("dir_out", out1, 8);
        check("dir_tc", tc1, 0);
        check("dir_wr", wr1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
